irq_fetch_ctrl: RTL and testbench

//  Interrupt sequencer for the fetch stage. Latches level IRQ sources, picks one
//  (fixed priority), waits for a safe redirect slot, then pulses `interrupt` into

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_irq_fetch_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared state encoding and vector defaults for the fetch-stage interrupt sequencer
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HANDLER = 2'd3
  } irq_state_e;

  localparam int unsigned IRQ_ID_W = 5;

  localparam logic [31:0] IRQ_VECTOR_BASE_DEF = 32'h0000_0100;
  localparam logic [31:0] IRQ_VEC_STRIDE_DEF  = 32'h0000_0004;

  // Vector address wraps modulo 2^32 by construction of the 32-bit sum.
  function automatic logic [31:0] irq_vector_addr(
    input logic [31:0]         base,
    input logic [31:0]         stride,
    input logic [IRQ_ID_W-1:0] id
  );
    irq_vector_addr = base + ({{(32-IRQ_ID_W){1'b0}}, id} * stride);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder for interrupt requests
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0]    req,
  output logic                found,
  output logic [IRQ_ID_W-1:0] id
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    found = 1'b0;
    id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        id    = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_fetch_ctrl.sv
// rtl/irq_fetch_ctrl.sv - interrupt sequencer that redirects fetch to a per-source vector
module irq_fetch_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ       = 8,
  parameter logic [31:0] VECTOR_BASE = IRQ_VECTOR_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE  = IRQ_VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             glb_en,
  input  logic             Stall_F,
  input  logic             PCSrc_E,
  input  logic             valid_D,
  input  logic [31:0]      PC_D,
  input  logic             mret_E,
  output logic             interrupt,
  output logic [31:0]      irq_vector,
  output logic             Flush_D,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [4:0]       irq_id,
  output logic [31:0]      epc,
  output logic             in_handler
);

  irq_state_e          state_q, state_d;
  logic [N_IRQ-1:0]    pending_q, pending_d;
  logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;
  logic [31:0]         epc_q, epc_d;

  logic [N_IRQ-1:0]    eligible;
  logic                found;
  logic [IRQ_ID_W-1:0] win_id;

  assign eligible = pending_q & irq_mask;

  irq_prio_enc #(
    .N_IRQ (N_IRQ)
  ) u_prio_enc (
    .req   (eligible),
    .found (found),
    .id    (win_id)
  );

  // FIRE-cycle pulses and handler status, decoded purely from registered state.
  always_comb begin
    interrupt  = 1'b0;
    Flush_D    = 1'b0;
    irq_ack    = '0;
    irq_vector = '0;
    in_handler = 1'b0;
    if (state_q == ST_FIRE) begin
      interrupt  = 1'b1;
      Flush_D    = 1'b1;
      in_handler = 1'b1;
      irq_vector = irq_vector_addr(VECTOR_BASE, VEC_STRIDE, irq_id_q);
      for (int i = 0; i < int'(N_IRQ); i++) begin
        irq_ack[i] = (irq_id_q == IRQ_ID_W'(i));
      end
    end
    if (state_q == ST_HANDLER) begin
      in_handler = 1'b1;
    end
  end

  // Latch new requests; the ack only clears a bit that is not being re-raised.
  always_comb begin
    pending_d = (pending_q & ~irq_ack) | irq_src;
  end

  // Sequencer: arm on an eligible request, fire in a safe slot, wait for mret.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    epc_d    = epc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (glb_en && found) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!glb_en || !found) begin
          state_d = ST_IDLE;
        end else if (!Stall_F && !PCSrc_E && valid_D) begin
          state_d  = ST_FIRE;
          irq_id_d = win_id;
        end
      end
      ST_FIRE: begin
        epc_d   = PC_D;
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (mret_E) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      irq_id_q  <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
      epc_q     <= epc_d;
    end
  end

  assign irq_id = irq_id_q;
  assign epc    = epc_q;

endmodule

// File: tb/tb_irq_fetch_ctrl.sv
// tb/tb_irq_fetch_ctrl.sv - self-checking bench for irq_fetch_ctrl
module tb_irq_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src, irq_mask;
  logic        glb_en, Stall_F, PCSrc_E, valid_D, mret_E;
  logic [31:0] PC_D;
  logic        interrupt, Flush_D, in_handler;
  logic [31:0] irq_vector, epc;
  logic [7:0]  irq_ack;
  logic [4:0]  irq_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_fetch_ctrl #(
    .N_IRQ       (8),
    .VECTOR_BASE (32'h0000_0100),
    .VEC_STRIDE  (32'h4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .irq_mask   (irq_mask),
    .glb_en     (glb_en),
    .Stall_F    (Stall_F),
    .PCSrc_E    (PCSrc_E),
    .valid_D    (valid_D),
    .PC_D       (PC_D),
    .mret_E     (mret_E),
    .interrupt  (interrupt),
    .irq_vector (irq_vector),
    .Flush_D    (Flush_D),
    .irq_ack    (irq_ack),
    .irq_id     (irq_id),
    .epc        (epc),
    .in_handler (in_handler)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq_src  = 8'h00;
    irq_mask = 8'hFF;
    glb_en   = 1'b1;
    Stall_F  = 1'b0;
    PCSrc_E  = 1'b0;
    valid_D  = 1'b1;
    mret_E   = 1'b0;
    PC_D     = 32'h40;
  endtask

  task automatic wait_fire(input int budget, output int cycles);
    cycles = 0;
    while (interrupt !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic finish_handler();
    tick();
    mret_E = 1'b1;
    tick();
    mret_E = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({interrupt, Flush_D, in_handler, irq_ack, irq_id, irq_vector, epc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got int=%b fl=%b ih=%b ack=%h id=%0d vec=%h epc=%h want all 0",
               interrupt, Flush_D, in_handler, irq_ack, irq_id, irq_vector, epc);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (interrupt !== 1'b0 || in_handler !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got int=%b ih=%b want 0 0", interrupt, in_handler);
    end
  endtask

  task automatic test_single();
    int  cyc;
    logic seen;
    idle_inputs();
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    wait_fire(10, cyc);
    checks++;
    if (cyc != 2) begin errors++; $display("FAIL single_latency got %0d want 2", cyc); end
    checks++;
    if (irq_vector !== 32'h108) begin errors++; $display("FAIL single_vector got %h want 108", irq_vector); end
    checks++;
    if (irq_ack !== 8'h04) begin errors++; $display("FAIL single_ack got %h want 04", irq_ack); end
    checks++;
    if (irq_id !== 5'd2) begin errors++; $display("FAIL single_id got %0d want 2", irq_id); end
    checks++;
    if (Flush_D !== 1'b1 || in_handler !== 1'b1) begin
      errors++; $display("FAIL single_flush_ih got %b %b want 1 1", Flush_D, in_handler);
    end
    tick();
    checks++;
    if (interrupt !== 1'b0 || Flush_D !== 1'b0 || irq_ack !== 8'h00) begin
      errors++; $display("FAIL single_pulse_width got int=%b fl=%b ack=%h want 0 0 00", interrupt, Flush_D, irq_ack);
    end
    checks++;
    if (epc !== 32'h40) begin errors++; $display("FAIL single_epc got %h want 40", epc); end
    checks++;
    if (in_handler !== 1'b1) begin errors++; $display("FAIL single_in_handler got %b want 1", in_handler); end
    mret_E = 1'b1;
    tick();
    mret_E = 1'b0;
    checks++;
    if (in_handler !== 1'b0) begin errors++; $display("FAIL single_mret got ih=%b want 0", in_handler); end
    seen = 1'b0;
    repeat (5) begin tick(); if (interrupt === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL single_no_refire got %b want 0", seen); end
  endtask

  task automatic test_priority();
    int cyc;
    idle_inputs();
    irq_src = 8'h0A;
    tick();
    irq_src = 8'h00;
    wait_fire(10, cyc);
    checks++;
    if (cyc != 2 || irq_id !== 5'd1 || irq_vector !== 32'h104 || irq_ack !== 8'h02) begin
      errors++;
      $display("FAIL prio_first got cyc=%0d id=%0d vec=%h ack=%h want 2 1 104 02", cyc, irq_id, irq_vector, irq_ack);
    end
    tick();
    mret_E = 1'b1;
    tick();
    mret_E = 1'b0;
    wait_fire(10, cyc);
    checks++;
    if (cyc != 2 || irq_id !== 5'd3 || irq_vector !== 32'h10C || irq_ack !== 8'h08) begin
      errors++;
      $display("FAIL prio_second got cyc=%0d id=%0d vec=%h ack=%h want 2 3 10c 08", cyc, irq_id, irq_vector, irq_ack);
    end
    finish_handler();
  endtask

  task automatic test_stall_branch();
    logic seen;
    idle_inputs();
    Stall_F = 1'b1;
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    seen = 1'b0;
    repeat (3) begin tick(); if (interrupt === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL stall_blocks got %b want 0", seen); end
    Stall_F = 1'b0;
    PCSrc_E = 1'b1;
    tick();
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL branch_blocks got %b want 0", interrupt); end
    PCSrc_E = 1'b0;
    valid_D = 1'b0;
    tick();
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL bubble_blocks got %b want 0", interrupt); end
    valid_D = 1'b1;
    tick();
    checks++;
    if (interrupt !== 1'b1 || irq_id !== 5'd0 || irq_vector !== 32'h100) begin
      errors++;
      $display("FAIL stall_release got int=%b id=%0d vec=%h want 1 0 100", interrupt, irq_id, irq_vector);
    end
    finish_handler();
  endtask

  task automatic test_nesting();
    int   cyc;
    logic seen, left;
    idle_inputs();
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    wait_fire(10, cyc);
    tick();
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    seen = 1'b0;
    left = 1'b0;
    repeat (6) begin
      tick();
      if (interrupt === 1'b1) seen = 1'b1;
      if (in_handler !== 1'b1) left = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || left !== 1'b0) begin
      errors++; $display("FAIL nest_blocked got fired=%b left=%b want 0 0", seen, left);
    end
    mret_E = 1'b1;
    tick();
    mret_E = 1'b0;
    wait_fire(10, cyc);
    checks++;
    if (cyc != 2 || irq_id !== 5'd0 || irq_vector !== 32'h100 || irq_ack !== 8'h01) begin
      errors++;
      $display("FAIL nest_after_mret got cyc=%0d id=%0d vec=%h ack=%h want 2 0 100 01", cyc, irq_id, irq_vector, irq_ack);
    end
    finish_handler();
    PC_D   = 32'h1234;
    mret_E = 1'b1;
    tick();
    mret_E = 1'b0;
    tick();
    checks++;
    if (epc !== 32'h40 || in_handler !== 1'b0 || interrupt !== 1'b0) begin
      errors++;
      $display("FAIL stray_mret got epc=%h ih=%b int=%b want 40 0 0", epc, in_handler, interrupt);
    end
    PC_D = 32'h40;
  endtask

  task automatic test_mask_glb();
    int   cyc;
    logic seen;
    idle_inputs();
    irq_mask = 8'hDF;
    irq_src  = 8'h20;
    tick();
    irq_src = 8'h00;
    seen = 1'b0;
    repeat (10) begin tick(); if (interrupt === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL masked_held got %b want 0", seen); end
    irq_mask = 8'hFF;
    wait_fire(10, cyc);
    checks++;
    if (cyc != 2 || irq_id !== 5'd5 || irq_vector !== 32'h114 || irq_ack !== 8'h20) begin
      errors++;
      $display("FAIL unmask_fire got cyc=%0d id=%0d vec=%h ack=%h want 2 5 114 20", cyc, irq_id, irq_vector, irq_ack);
    end
    finish_handler();
    Stall_F = 1'b1;
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    tick();
    glb_en  = 1'b0;
    Stall_F = 1'b0;
    seen = 1'b0;
    repeat (5) begin tick(); if (interrupt === 1'b1 || in_handler === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glb_off_abort got %b want 0", seen); end
    glb_en = 1'b1;
    wait_fire(10, cyc);
    checks++;
    if (cyc != 2 || irq_id !== 5'd3) begin
      errors++; $display("FAIL glb_on_fire got cyc=%0d id=%0d want 2 3", cyc, irq_id);
    end
    finish_handler();
  endtask

  task automatic test_reset_mid();
    int   cyc;
    logic seen;
    idle_inputs();
    Stall_F = 1'b1;
    irq_src = 8'h02;
    tick();
    irq_src = 8'h00;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({interrupt, Flush_D, in_handler, irq_ack, irq_id, irq_vector} !== '0) begin
      errors++; $display("FAIL rst_in_arm got int=%b ih=%b id=%0d want 0", interrupt, in_handler, irq_id);
    end
    #2;
    rst = 1'b1;
    Stall_F = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); if (interrupt === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_arm_pending got %b want 0", seen); end
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    wait_fire(10, cyc);
    rst = 1'b0;
    #1;
    checks++;
    if ({interrupt, Flush_D, in_handler, irq_ack, irq_id, irq_vector, epc} !== '0) begin
      errors++;
      $display("FAIL rst_in_fire got int=%b fl=%b ih=%b ack=%h id=%0d epc=%h want 0",
               interrupt, Flush_D, in_handler, irq_ack, irq_id, epc);
    end
    #2;
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin tick(); if (interrupt === 1'b1 || in_handler === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_fire_pending got %b want 0", seen); end
  endtask

  task automatic test_random();
    logic [7:0]  m_pend, elig, iso, clr;
    logic [4:0]  m_id, low;
    logic [31:0] m_epc, exp_vec;
    logic        m_armed, m_fire, m_handler;
    logic        n_armed, n_fire, n_handler, any;
    rst = 1'b0;
    idle_inputs();
    #2;
    rst = 1'b1;
    m_pend = 0; m_id = 0; m_epc = 0;
    m_armed = 0; m_fire = 0; m_handler = 0;
    for (int c = 0; c < 400; c++) begin
      irq_src  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      irq_mask = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
      glb_en   = ($urandom_range(0, 19) != 0);
      Stall_F  = ($urandom_range(0, 3) == 0);
      PCSrc_E  = ($urandom_range(0, 6) == 0);
      valid_D  = ($urandom_range(0, 6) != 0);
      mret_E   = ($urandom_range(0, 4) == 0);
      PC_D     = $urandom & 32'hFFFF_FFFC;
      tick();
      elig      = m_pend & irq_mask;
      any       = (elig != 8'h00);
      iso       = elig & (~elig + 8'd1);
      low       = any ? 5'($clog2(iso)) : 5'd0;
      n_fire    = m_armed && glb_en && any && !Stall_F && !PCSrc_E && valid_D;
      n_armed   = glb_en && any && ((m_armed && !n_fire) || (!m_armed && !m_fire && !m_handler));
      n_handler = m_fire || (m_handler && !mret_E);
      clr       = m_fire ? (8'h01 << m_id) : 8'h00;
      m_pend    = (m_pend & ~clr) | irq_src;
      if (m_fire) m_epc = PC_D;
      if (n_fire) m_id = low;
      m_fire    = n_fire;
      m_armed   = n_armed;
      m_handler = n_handler;
      exp_vec   = m_fire ? (32'h100 + 32'(m_id) * 32'd4) : 32'h0;
      checks++;
      if (interrupt !== m_fire || Flush_D !== m_fire) begin
        errors++; $display("FAIL rnd_pulse c=%0d got int=%b fl=%b want %b", c, interrupt, Flush_D, m_fire);
      end
      checks++;
      if (in_handler !== (m_fire || m_handler)) begin
        errors++; $display("FAIL rnd_in_handler c=%0d got %b want %b", c, in_handler, m_fire || m_handler);
      end
      checks++;
      if (irq_vector !== exp_vec || irq_ack !== (m_fire ? (8'h01 << m_id) : 8'h00)) begin
        errors++; $display("FAIL rnd_vector c=%0d got vec=%h ack=%h want vec=%h", c, irq_vector, irq_ack, exp_vec);
      end
      checks++;
      if (irq_id !== m_id || epc !== m_epc) begin
        errors++; $display("FAIL rnd_id_epc c=%0d got id=%0d epc=%h want id=%0d epc=%h", c, irq_id, epc, m_id, m_epc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_stall_branch();
    test_nesting();
    test_mask_glb();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
